// File: rtl/cart_mapper.sv
// ============================================================================
// Module   : cart_mapper
// Purpose  : Cartridge bank-switch mapper (2K/4K/F8/F6/F4) with Superchip RAM.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cart_mapper #(
  parameter int ROM_ADDR_BITS = 15,
  parameter int SC_DEPTH      = 128
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [2:0]               mode_i,
  input  logic                     sc_en_i,
  input  logic                     cpu_enable_i,
  input  logic [12:0]              adr_i,
  input  logic                     we_i,
  input  logic [7:0]               dat_i,
  output logic [ROM_ADDR_BITS-1:0] rom_adr_o,
  input  logic [7:0]               rom_dat_i,
  output logic [7:0]               dat_o,
  output logic [2:0]               bank_o,
  output logic                     hotspot_o
);

  localparam int         c_SC_AW   = $clog2(SC_DEPTH);
  localparam logic [2:0] c_MODE_2K = 3'd0;
  localparam logic [2:0] c_MODE_4K = 3'd1;
  localparam logic [2:0] c_MODE_F8 = 3'd2;
  localparam logic [2:0] c_MODE_F6 = 3'd3;
  localparam logic [2:0] c_MODE_F4 = 3'd4;

  logic [2:0] r_mode_q;
  logic       r_sc_q;
  logic [2:0] r_bank;
  logic       r_hot;
  logic       r_sel_sc;
  logic [7:0] r_ram_q;
  logic [7:0] r_ram [SC_DEPTH];

  logic [2:0]  w_mode_norm;
  logic [2:0]  w_bank_rst;
  logic        w_banked;
  logic        w_hs_hit;
  logic [2:0]  w_hs_bank;
  logic        w_sc_on;
  logic        w_wr_win;
  logic        w_rd_win;
  logic [14:0] w_rom_adr;

  // Unused encodings 5-7 fall back to plain 4K.
  assign w_mode_norm = (mode_i > c_MODE_F4) ? c_MODE_4K : mode_i;

  always_comb begin
    w_bank_rst = 3'd0;
    case (w_mode_norm)
      c_MODE_F8: w_bank_rst = 3'd1;
      c_MODE_F6: w_bank_rst = 3'd3;
      c_MODE_F4: w_bank_rst = 3'd7;
      default:   w_bank_rst = 3'd0;
    endcase
  end

  assign w_banked = (r_mode_q == c_MODE_F8) || (r_mode_q == c_MODE_F6) ||
                    (r_mode_q == c_MODE_F4);

  // All hotspots live in $1FF4..$1FFB; the low nibble selects the bank.
  always_comb begin
    w_hs_hit  = 1'b0;
    w_hs_bank = 3'd0;
    if (adr_i[12] && (adr_i[11:4] == 8'hFF)) begin
      case (r_mode_q)
        c_MODE_F8: begin
          w_hs_hit  = (adr_i[3:0] == 4'h8) || (adr_i[3:0] == 4'h9);
          w_hs_bank = {2'b00, adr_i[0]};
        end
        c_MODE_F6: begin
          w_hs_hit  = (adr_i[3:0] >= 4'h6) && (adr_i[3:0] <= 4'h9);
          w_hs_bank = adr_i[2:0] - 3'd6;
        end
        c_MODE_F4: begin
          w_hs_hit  = (adr_i[3:0] >= 4'h4) && (adr_i[3:0] <= 4'hB);
          w_hs_bank = adr_i[2:0] - 3'd4;
        end
        default: begin
          w_hs_hit  = 1'b0;
          w_hs_bank = 3'd0;
        end
      endcase
    end
  end

  always_comb begin
    w_rom_adr = {3'b000, adr_i[11:0]};
    case (r_mode_q)
      c_MODE_2K: w_rom_adr = {4'b0000, adr_i[10:0]};
      c_MODE_4K: w_rom_adr = {3'b000, adr_i[11:0]};
      c_MODE_F8: w_rom_adr = {2'b00, r_bank[0], adr_i[11:0]};
      c_MODE_F6: w_rom_adr = {1'b0, r_bank[1:0], adr_i[11:0]};
      c_MODE_F4: w_rom_adr = {r_bank, adr_i[11:0]};
      default:   w_rom_adr = {3'b000, adr_i[11:0]};
    endcase
  end

  assign rom_adr_o = w_rom_adr;

  assign w_sc_on  = r_sc_q && w_banked;
  assign w_wr_win = (adr_i[12:7] == 6'b100000);
  assign w_rd_win = (adr_i[12:7] == 6'b100001);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_mode_q <= w_mode_norm;
      r_sc_q   <= sc_en_i;
      r_bank   <= w_bank_rst;
      r_hot    <= 1'b0;
      r_sel_sc <= 1'b0;
    end else begin
      r_hot    <= cpu_enable_i && w_hs_hit;
      r_sel_sc <= w_sc_on && w_rd_win;
      if (cpu_enable_i && w_hs_hit) begin
        r_bank <= w_hs_bank;
      end
    end
  end

  // Superchip RAM is deliberately outside reset so contents survive it.
  always_ff @(posedge clk_i) begin
    r_ram_q <= r_ram[adr_i[c_SC_AW-1:0]];
    if (!rst_i && cpu_enable_i && we_i && w_sc_on && w_wr_win) begin
      r_ram[adr_i[c_SC_AW-1:0]] <= dat_i;
    end
  end

  assign dat_o     = r_sel_sc ? r_ram_q : rom_dat_i;
  assign bank_o    = r_bank;
  assign hotspot_o = r_hot;

endmodule

`default_nettype wire

// File: tb/tb_cart_mapper.sv
// ============================================================================
// Module   : tb_cart_mapper
// Purpose  : Scoreboard bench for cart_mapper with a behavioural mapper model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_cart_mapper;

  logic        clk;
  logic        rst_i;
  logic [2:0]  mode_i;
  logic        sc_en_i;
  logic        cpu_enable_i;
  logic [12:0] adr_i;
  logic        we_i;
  logic [7:0]  dat_i;
  logic [14:0] rom_adr_o;
  logic [7:0]  rom_dat_i;
  logic [7:0]  dat_o;
  logic [2:0]  bank_o;
  logic        hotspot_o;

  cart_mapper #(.ROM_ADDR_BITS(15), .SC_DEPTH(128)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .mode_i       (mode_i),
    .sc_en_i      (sc_en_i),
    .cpu_enable_i (cpu_enable_i),
    .adr_i        (adr_i),
    .we_i         (we_i),
    .dat_i        (dat_i),
    .rom_adr_o    (rom_adr_o),
    .rom_dat_i    (rom_dat_i),
    .dat_o        (dat_o),
    .bank_o       (bank_o),
    .hotspot_o    (hotspot_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] rom_fn(input logic [14:0] a);
    return a[7:0] ^ {1'b0, a[14:8]} ^ 8'h5A;
  endfunction

  // Synchronous ROM image.
  always @(posedge clk) rom_dat_i <= rom_fn(rom_adr_o);

  typedef struct {
    logic [14:0] adr;
    logic [2:0]  bank;
    logic        hot;
    logic [7:0]  dat;
    bit          dat_chk;
  } exp_t;

  exp_t exq[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  int         m_mode;
  bit         m_sc;
  int         m_bank;
  bit         m_hot;
  logic [7:0] m_dat;
  bit         m_dat_ok;
  logic [7:0] m_ram    [128];
  bit         m_ram_ok [128];

  function automatic int norm_mode(input int m);
    return (m > 4) ? 1 : m;
  endfunction

  function automatic int nbanks(input int m);
    case (m)
      2: return 2;
      3: return 4;
      4: return 8;
      default: return 1;
    endcase
  endfunction

  function automatic int hs_base(input int m);
    case (m)
      2: return 'h1FF8;
      3: return 'h1FF6;
      4: return 'h1FF4;
      default: return 'h7FFF;
    endcase
  endfunction

  function automatic int xlate(input int m, input int b, input int a);
    if (m == 0) return a % 2048;
    if (m == 1) return a % 4096;
    return (b % nbanks(m)) * 4096 + a % 4096;
  endfunction

  task automatic step(input bit r, input bit e, input logic [12:0] a,
                      input bit w, input logic [7:0] d);
    exp_t x;
    int   ai;
    int   xa;
    int   base;
    bit   sc_on;
    rst_i        = r;
    cpu_enable_i = e;
    adr_i        = a;
    we_i         = w;
    dat_i        = d;
    ai = int'(a);
    xa = xlate(m_mode, m_bank, ai);
    x.adr     = 15'(xa);
    x.bank    = 3'(m_bank);
    x.hot     = m_hot;
    x.dat     = m_dat;
    x.dat_chk = m_dat_ok;
    exq.push_back(x);
    if (r) begin
      m_mode   = norm_mode(int'(mode_i));
      m_sc     = sc_en_i;
      m_bank   = nbanks(m_mode) - 1;
      m_hot    = 1'b0;
      m_dat    = rom_fn(15'(xa));
      m_dat_ok = 1'b1;
    end else begin
      sc_on = m_sc && (m_mode >= 2);
      if (sc_on && ai >= 'h1080 && ai <= 'h10FF) begin
        m_dat    = m_ram[ai % 128];
        m_dat_ok = m_ram_ok[ai % 128];
      end else begin
        m_dat    = rom_fn(15'(xa));
        m_dat_ok = 1'b1;
      end
      if (sc_on && e && w && ai >= 'h1000 && ai <= 'h107F) begin
        m_ram[ai % 128]    = d;
        m_ram_ok[ai % 128] = 1'b1;
      end
      m_hot = 1'b0;
      base  = hs_base(m_mode);
      if (e && ai >= base && ai < base + nbanks(m_mode)) begin
        m_bank = ai - base;
        m_hot  = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [2:0] m, input bit sc);
    mode_i  = m;
    sc_en_i = sc;
    step(1'b1, 1'b0, 13'h0000, 1'b0, 8'h00);
  endtask

  task automatic chk(input string nm, input logic [14:0] act, input logic [14:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  // Monitor: one expected record per clock, compared mid-cycle.
  always @(negedge clk) begin
    exp_t x;
    if (exq.size() > 0) begin
      x = exq.pop_front();
      chk("rom_adr", rom_adr_o, x.adr);
      chk("bank", 15'(bank_o), 15'(x.bank));
      chk("hotspot", 15'(hotspot_o), 15'(x.hot));
      if (x.dat_chk) chk("dat", 15'(dat_o), 15'(x.dat));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [12:0] a;
    for (int i = 0; i < 128; i++) m_ram_ok[i] = 1'b0;
    rst_i = 1'b1; mode_i = 3'd2; sc_en_i = 1'b0;
    cpu_enable_i = 1'b0; adr_i = 13'h0; we_i = 1'b0; dat_i = 8'h0;
    @(posedge clk);
    #1;
    m_mode = 2; m_sc = 1'b0; m_bank = 1; m_hot = 1'b0; m_dat = 8'h00; m_dat_ok = 1'b0;

    // F8 basic switch
    do_reset(3'd2, 1'b0);
    step(0, 1, 13'h1000, 0, 8'h00);
    step(0, 1, 13'h1FF8, 0, 8'h00);
    step(0, 1, 13'h1000, 0, 8'h00);
    step(0, 0, 13'h1000, 0, 8'h00);

    // F4 walk through every hotspot, then a banked read and a non-hotspot
    do_reset(3'd4, 1'b0);
    for (int i = 0; i < 8; i++) step(0, 1, 13'h1FF4 + 13'(i), 0, 8'h00);
    step(0, 1, 13'h1FF9, 0, 8'h00);
    step(0, 1, 13'h1ABC, 0, 8'h00);
    step(0, 1, 13'h1FFC, 0, 8'h00);
    step(0, 0, 13'h1ABC, 0, 8'h00);

    // F6: unstrobed hotspot must not switch
    do_reset(3'd3, 1'b0);
    for (int i = 0; i < 10; i++) step(0, 0, 13'h1FF6, 0, 8'h00);
    step(0, 1, 13'h1FF6, 0, 8'h00);
    step(0, 0, 13'h1000, 0, 8'h00);

    // Superchip windows
    do_reset(3'd2, 1'b1);
    step(0, 1, 13'h1005, 1, 8'hA5);
    step(0, 1, 13'h1085, 0, 8'h00);
    step(0, 0, 13'h1200, 0, 8'h00);
    step(0, 1, 13'h1085, 1, 8'h3C);
    step(0, 1, 13'h1085, 0, 8'h00);
    step(0, 1, 13'h1005, 0, 8'h00);
    step(0, 0, 13'h1200, 0, 8'h00);

    // 2K mirroring, no hotspots, mode change ignored without reset
    do_reset(3'd0, 1'b0);
    step(0, 1, 13'h1800, 0, 8'h00);
    step(0, 1, 13'h1000, 0, 8'h00);
    step(0, 1, 13'h1FF8, 0, 8'h00);
    mode_i = 3'd4;
    step(0, 1, 13'h1FF5, 0, 8'h00);
    step(0, 1, 13'h1ABC, 0, 8'h00);

    // Reset mid-operation with a strobed hotspot; SC RAM survives
    do_reset(3'd4, 1'b1);
    step(0, 1, 13'h1010, 1, 8'h5A);
    step(0, 1, 13'h1FF6, 0, 8'h00);
    step(0, 1, 13'h1ABC, 0, 8'h00);
    step(1, 1, 13'h1FF5, 0, 8'h00);
    step(0, 1, 13'h1090, 0, 8'h00);
    step(0, 0, 13'h1000, 0, 8'h00);

    // Randomized segments
    for (int s = 0; s < 12; s++) begin
      do_reset(3'($urandom_range(0, 7)), bit'($urandom_range(0, 1)));
      for (int c = 0; c < 250; c++) begin
        case ($urandom_range(0, 3))
          0: a = 13'h1FF0 + 13'($urandom_range(0, 15));
          1: a = 13'h1000 + 13'($urandom_range(0, 255));
          2: a = 13'($urandom_range(0, 8191));
          default: a = 13'h1000 + 13'($urandom_range(0, 4095));
        endcase
        if ($urandom_range(0, 19) == 0) mode_i = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 19) == 0) sc_en_i = bit'($urandom_range(0, 1));
        step(bit'($urandom_range(0, 59) == 0), bit'($urandom_range(0, 2) != 0), a,
             bit'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
      end
    end

    step(0, 0, 13'h0000, 0, 8'h00);
    @(negedge clk);
    @(negedge clk);
    n_chk++;
    if (exq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d records left, expected 0", exq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cart_mapper.md
Name: cart_mapper

Overview:
Cartridge bank-switch mapper. It sits between the 6502 address bus and the 32 KB cartridge ROM (dprom), and handles ROMs larger than 4 KB.
- Translates the 13-bit CPU address into a 15-bit ROM address from the selected bank scheme and the current bank register.
- Detects hotspot accesses and updates the bank register.
- Optionally provides 128 bytes of Superchip (SC) RAM inside the cartridge window.
- Returns the cartridge read data to the top-level CPU data mux for the rom_cs branch.

Parameters:
ROM_ADDR_BITS, 15, width of rom_adr_o; fixed 32 KB max image.
SC_DEPTH, 128, Superchip RAM bytes; must be 128.

Ports:
clk_i  in  1  system clock (clk_sys)
rst_i  in  1  synchronous reset, active-high
mode_i  in  3  scheme: 0=2K, 1=4K, 2=F8 (8K), 3=F6 (16K), 4=F4 (32K), 5-7 treated as 4K
sc_en_i  in  1  Superchip RAM enable
cpu_enable_i  in  1  one-clk strobe per CPU cycle; address/we qualified
adr_i  in  13  CPU address A12..A0
we_i  in  1  CPU write (active-high, = !rnw)
dat_i  in  8  CPU write data
rom_adr_o  out  15  ROM byte address (combinational)
rom_dat_i  in  8  ROM data, 1-clk synchronous read
dat_o  out  8  cartridge read data to CPU mux
bank_o  out  3  current bank register (diagnostics)
hotspot_o  out  1  1-clk pulse when a bank switch is accepted

Behaviour:
Mode latch:
- mode_q and sc_q are latched from mode_i and sc_en_i only while rst_i=1.
- A mode change takes effect only through a reset.

Reset values:
- bank = highest bank of the latched mode: 2K/4K=0, F8=1, F6=3, F4=7.
- hotspot_o=0; sel_sc_q=0, so dat_o=rom_dat_i.
- SC RAM contents are not cleared.
- Reset asserted mid-operation: the bank reverts on the next clock edge and any strobed access in that cycle is ignored.

Address translation (combinational, uses the registered bank):
- 2K: {4'b0, adr_i[10:0]} (mirrored).
- 4K: {3'b0, adr_i[11:0]}.
- F8: {2'b0, bank[0], adr_i[11:0]}.
- F6: {1'b0, bank[1:0], adr_i[11:0]}.
- F4: {bank[2:0], adr_i[11:0]}.

Hotspots (require cpu_enable_i=1, adr_i[12]=1, rst_i=0; reads and writes both qualify):
- F8: $1FF8→0, $1FF9→1.
- F6: $1FF6..$1FF9 → 0..3.
- F4: $1FF4..$1FFB → 0..7.
- 2K/4K: no hotspots.

Bank switch timing:
- The bank register updates at the clock edge that samples the strobe.
- The hotspot access itself is translated with the old bank; the new bank applies to all later addresses.
- hotspot_o pulses high for exactly 1 clk after that edge, including when the new bank equals the old one.
- Accesses without cpu_enable_i never switch the bank.

Superchip (active only when sc_q=1 and mode is F8/F6/F4):
- Write window $1000-$107F: when cpu_enable_i & we_i, write dat_i into RAM[adr_i[6:0]].
- Read window $1080-$10FF: RAM is read synchronously every clk at adr_i[6:0].
- sel_sc_q is registered every clk = (read window hit).
- dat_o = sel_sc_q ? ram_q : rom_dat_i; latency is 1 clk from address, identical to the ROM path.
- A write into the read window is ignored. A read from the write window returns ROM data.
- Superchip is ignored in 2K/4K modes, and when sc_q=0.

Test Plan:
- Reset with mode_i=2: bank_o=1; strobed read $1000 gives rom_adr_o=$1000. Strobed read $1FF8: rom_adr_o=$1FF8 during the access, then bank_o=0, hotspot_o one 1-clk pulse; next read $1000 gives rom_adr_o=$0000.
- Mode 4 (F4): strobe $1FF4..$1FFB in turn; bank_o steps 0..7. Read $1ABC with bank 5 gives rom_adr_o=$5ABC. $1FFC strobed: no switch, no pulse.
- Mode 3 (F6), bank 3: hotspot $1FF6 presented with cpu_enable_i=0 for 10 clks gives no switch; one strobe then gives bank_o=0.
- Mode 2 with sc_en_i=1:
  - Write $A5 to $1005, then read $1085: dat_o=$A5 one clk after the address.
  - Write to $1085: RAM[5] stays $A5.
  - Read $1005: dat_o=rom_dat_i.
- Mode 0 (2K): $1800 and $1000 both map to rom_adr_o=$0000; $1FF8 strobed gives no hotspot_o. Drive mode_i=4 without reset: behaviour stays 2K.
- Mode 4, bank 2, then assert rst_i for 1 clk together with a strobed $1FF5: bank_o=7 after reset, hotspot_o=0, and a prior SC write is still readable.
